// File: rtl/sync_down_timer_pkg.sv
// rtl/sync_down_timer_pkg.sv - shared state encodings and defaults for the down timer
package sync_down_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sync_down_timer_if.sv
// rtl/sync_down_timer_if.sv - control and status bundle of the down timer
interface sync_down_timer_if
  import sync_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             busy;
  logic             done;

  // Controller side: drives the strobes, observes the count
  modport master (
    output en, load, load_val, auto_reload,
    input  q, q_n, busy, done
  );

  // Timer side
  modport slave (
    input  en, load, load_val, auto_reload,
    output q, q_n, busy, done
  );

endinterface

// File: rtl/t_ff_n.sv
// rtl/t_ff_n.sv - toggle flip-flop with asynchronous active-low clear
module t_ff_n (
  input  logic T,
  input  logic clk,
  input  logic rst,
  output logic Q,
  output logic Q_n
);

  // Flip on T, clear immediately when rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

  assign Q_n = ~Q;

endmodule

// File: rtl/sync_down_timer.sv
// rtl/sync_down_timer.sv - loadable down counter with IDLE/RUN/DONE control and auto reload
module sync_down_timer
  import sync_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  sync_down_timer_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] dec_tog;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] rl;

  // A bit flips on decrement when every bit below it is zero (borrow chain)
  assign dec_tog[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_dec
    assign dec_tog[i] = &q_n[i-1:0];
  end
  assign dec = q ^ dec_tog;

  // Each count bit is a T flop toggled exactly where the chosen next value differs
  assign tog = q ^ nxt;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_n u_bit (
      .T   (tog[i]),
      .clk (clk),
      .rst (rst),
      .Q   (q[i]),
      .Q_n (q_n[i])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reload register remembers the most recent load value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rl <= '0;
    end else if (bus.load) begin
      rl <= bus.load_val;
    end
  end

  // Next state and next count; load overrides everything else
  always_comb begin
    state_nxt = state;
    nxt       = q;
    if (bus.load) begin
      nxt       = bus.load_val;
      state_nxt = (bus.load_val != '0) ? RUN : DONE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        RUN: begin
          if (bus.en) begin
            // Reaching zero ends the run; the <= guard keeps q from ever wrapping
            if (q <= WIDTH'(1)) begin
              nxt       = '0;
              state_nxt = DONE;
            end else begin
              nxt = dec;
            end
          end
        end
        DONE: begin
          if (bus.auto_reload && (rl != '0)) begin
            nxt       = rl;
            state_nxt = RUN;
          end else begin
            nxt       = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          nxt       = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.q    = q;
  assign bus.q_n  = q_n;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_sync_down_timer.sv
// tb/tb_sync_down_timer.sv - directed self-checking bench for sync_down_timer
module tb_sync_down_timer;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  sync_down_timer_if #(.WIDTH(4)) bus ();

  sync_down_timer #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.q !== 4'h0) $display("FAIL rst_q: got %0h expected 0", bus.q); else passed++;
    checks++; if (bus.q_n !== 4'hF) $display("FAIL rst_qn: got %0h expected f", bus.q_n); else passed++;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL rst_flags: got busy=%0b done=%0b expected 0 0", bus.busy, bus.done); else passed++;
    tick();
    rst    = 1'b1;
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.q !== 4'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
        $display("FAIL idle_after_rst[%0d]: got q=%0h busy=%0b done=%0b expected 0 0 0", k, bus.q, bus.busy, bus.done);
      else passed++;
    end
  endtask

  task automatic test_count5();
    logic [3:0] e;
    bus.en = 1'b1; bus.auto_reload = 1'b0;
    do_load(4'd5);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      e = (k < 6) ? 4'(5 - k) : 4'd0;
      checks++;
      if (bus.q !== e || bus.q_n !== ~e || bus.busy !== (k < 5) || bus.done !== (k == 5))
        $display("FAIL count5[%0d]: got q=%0h qn=%0h busy=%0b done=%0b expected q=%0h qn=%0h busy=%0b done=%0b",
                 k, bus.q, bus.q_n, bus.busy, bus.done, e, ~e, (k < 5), (k == 5));
      else passed++;
    end
  endtask

  task automatic test_enable_gaps();
    logic [4:0] en_seq;
    logic [3:0] exp_q [5];
    en_seq = 5'b10101;
    exp_q  = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    bus.en = 1'b1;
    do_load(4'd3);
    checks++; if (bus.q !== 4'd3 || bus.busy !== 1'b1)
      $display("FAIL gaps_load: got q=%0h busy=%0b expected 3 1", bus.q, bus.busy); else passed++;
    for (int k = 0; k < 5; k++) begin
      bus.en = en_seq[4-k];
      tick();
      checks++;
      if (bus.q !== exp_q[k] || bus.busy !== (k < 4) || bus.done !== (k == 4))
        $display("FAIL gaps[%0d]: got q=%0h busy=%0b done=%0b expected q=%0h busy=%0b done=%0b",
                 k, bus.q, bus.busy, bus.done, exp_q[k], (k < 4), (k == 4));
      else passed++;
    end
    bus.en = 1'b1;
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_q [7];
    logic [6:0] exp_done;
    logic [6:0] exp_busy;
    exp_q    = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    exp_done = 7'b0100100;
    exp_busy = 7'b1011000;
    bus.en = 1'b1; bus.auto_reload = 1'b1;
    do_load(4'd2);
    checks++; if (bus.q !== 4'd2) $display("FAIL ar_load: got %0h expected 2", bus.q); else passed++;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) bus.auto_reload = 1'b0;
      if (k == 2) bus.auto_reload = 1'b1;
      tick();
      checks++;
      if (bus.q !== exp_q[k] || bus.done !== exp_done[6-k] || bus.busy !== exp_busy[6-k])
        $display("FAIL autoreload[%0d]: got q=%0h done=%0b busy=%0b expected q=%0h done=%0b busy=%0b",
                 k, bus.q, bus.done, bus.busy, exp_q[k], exp_done[6-k], exp_busy[6-k]);
      else passed++;
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] e;
    bus.en = 1'b1; bus.auto_reload = 1'b0;
    do_load(4'd0);
    checks++; if (bus.q !== 4'd0 || bus.done !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL load0: got q=%0h done=%0b busy=%0b expected 0 1 0", bus.q, bus.done, bus.busy); else passed++;
    tick();
    checks++; if (bus.q !== 4'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL load0_idle: got q=%0h done=%0b busy=%0b expected 0 0 0", bus.q, bus.done, bus.busy); else passed++;
    do_load(4'd15);
    checks++; if (bus.q !== 4'd15 || bus.busy !== 1'b1)
      $display("FAIL load15: got q=%0h busy=%0b expected f 1", bus.q, bus.busy); else passed++;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = (k <= 15) ? 4'(15 - k) : 4'd0;
      checks++;
      if (bus.q !== e || bus.done !== (k == 15) || bus.busy !== (k < 15))
        $display("FAIL max[%0d]: got q=%0h done=%0b busy=%0b expected q=%0h done=%0b busy=%0b",
                 k, bus.q, bus.done, bus.busy, e, (k == 15), (k < 15));
      else passed++;
    end
  endtask

  task automatic test_load_override();
    bus.en = 1'b1; bus.auto_reload = 1'b0;
    do_load(4'd8);
    repeat (4) tick();
    checks++; if (bus.q !== 4'd4) $display("FAIL mid_pre: got %0h expected 4", bus.q); else passed++;
    bus.auto_reload = 1'b1;
    do_load(4'd9);
    checks++; if (bus.q !== 4'd9 || bus.busy !== 1'b1)
      $display("FAIL mid_load: got q=%0h busy=%0b expected 9 1", bus.q, bus.busy); else passed++;
    repeat (9) tick();
    checks++; if (bus.q !== 4'd0 || bus.done !== 1'b1)
      $display("FAIL mid_done: got q=%0h done=%0b expected 0 1", bus.q, bus.done); else passed++;
    tick();
    checks++; if (bus.q !== 4'd9 || bus.busy !== 1'b1)
      $display("FAIL reload_rl: got q=%0h busy=%0b expected 9 1", bus.q, bus.busy); else passed++;
    repeat (9) tick();
    checks++; if (bus.done !== 1'b1) $display("FAIL done2: got %0b expected 1", bus.done); else passed++;
    do_load(4'd7);
    checks++; if (bus.q !== 4'd7 || bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL load_in_done: got q=%0h busy=%0b done=%0b expected 7 1 0", bus.q, bus.busy, bus.done); else passed++;
    bus.auto_reload = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.en = 1'b1;
    bus.load = 1'b1; bus.load_val = 4'd4;
    tick();
    checks++; if (bus.q !== 4'd4) $display("FAIL b2b_first: got %0h expected 4", bus.q); else passed++;
    bus.load_val = 4'd2;
    tick();
    bus.load = 1'b0;
    checks++; if (bus.q !== 4'd2) $display("FAIL b2b_second: got %0h expected 2", bus.q); else passed++;
    tick(); tick();
    checks++; if (bus.q !== 4'd0 || bus.done !== 1'b1)
      $display("FAIL b2b_done: got q=%0h done=%0b expected 0 1", bus.q, bus.done); else passed++;
    tick();
  endtask

  task automatic test_async_reset();
    bus.en = 1'b1; bus.auto_reload = 1'b1;
    do_load(4'd8);
    tick(); tick();
    checks++; if (bus.q !== 4'd6) $display("FAIL ar_pre: got %0h expected 6", bus.q); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.q !== 4'd0 || bus.q_n !== 4'hF || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL async_rst: got q=%0h qn=%0h busy=%0b done=%0b expected 0 f 0 0",
               bus.q, bus.q_n, bus.busy, bus.done);
    else passed++;
    #1 rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (bus.q !== 4'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL post_rst[%0d]: got q=%0h done=%0b busy=%0b expected 0 0 0", k, bus.q, bus.done, bus.busy);
      else passed++;
    end
  endtask

  initial begin
    checks = 0; passed = 0;
    rst = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.load_val = 4'd0; bus.auto_reload = 1'b0;
    test_reset();
    test_count5();
    test_enable_gaps();
    test_auto_reload();
    test_boundaries();
    test_load_override();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
